// File: rtl/can_mem_arbiter_if.sv
// Avalon-MM master-side bundle for one arbiter port: request and
// write data toward the arbiter, waitrequest and read response back.
interface can_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/can_mem_arbiter.sv
// Two-port arbiter sharing the CAN controller's single-port RAM between
// the CPU data master (m0) and the frame-buffer DMA (m1). One access per
// clock, combinational grant, one-cycle read return steered to the issuer.
// Optional macro CAN_MEM_ARB_FIXED_PRIO_EN: m0 always wins contention;
// default build is round-robin on the last granted port.
module can_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  can_mem_arbiter_if.slave    m0,
  can_mem_arbiter_if.slave    m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic req0, req1;
  logic gnt_vld, gnt_idx;
  logic sel_write;
  logic last_q, last_d;
  logic rd_pend_q, rd_pend_d;
  logic rd_src_q, rd_src_d;

  // Grant decision: purely combinational so an accepted request never
  // waits a bubble cycle. Reset blocks every grant.
  always_comb begin
    req0    = m0.read | m0.write;
    req1    = m1.read | m1.write;
    gnt_vld = 1'b0;
    gnt_idx = 1'b0;
    if (!reset) begin
`ifdef CAN_MEM_ARB_FIXED_PRIO_EN
      if (req0) begin
        gnt_vld = 1'b1;
        gnt_idx = 1'b0;
      end else if (req1) begin
        gnt_vld = 1'b1;
        gnt_idx = 1'b1;
      end
`else
      if (req0 && req1) begin
        gnt_vld = 1'b1;
        gnt_idx = ~last_q;
      end else if (req0) begin
        gnt_vld = 1'b1;
        gnt_idx = 1'b0;
      end else if (req1) begin
        gnt_vld = 1'b1;
        gnt_idx = 1'b1;
      end
`endif
    end
  end

  // RAM-side mux and per-port handshake. With no grant gnt_idx is 0, so
  // the RAM address/data simply follow port 0.
  always_comb begin
    // Read+write together is treated as a write.
    sel_write         = gnt_idx ? m1.write : m0.write;
    mem_address       = gnt_idx ? m1.address : m0.address;
    mem_byteenable    = gnt_idx ? m1.byteenable : m0.byteenable;
    mem_writedata     = gnt_idx ? m1.writedata : m0.writedata;
    mem_chipselect    = gnt_vld;
    mem_write         = gnt_vld & sel_write;
    mem_clken         = 1'b1;
    m0.waitrequest    = ~(gnt_vld & ~gnt_idx);
    m1.waitrequest    = ~(gnt_vld & gnt_idx);
    m0.readdata       = mem_readdata;
    m1.readdata       = mem_readdata;
    // Gated by reset so a read in flight when reset hits is dropped.
    m0.readdatavalid  = rd_pend_q & ~rd_src_q & ~reset;
    m1.readdatavalid  = rd_pend_q & rd_src_q & ~reset;
  end

  // Next-state for the round-robin pointer and the read tracker.
  always_comb begin
    last_d    = gnt_vld ? gnt_idx : last_q;
    rd_pend_d = gnt_vld & ~sel_write;
    rd_src_d  = (gnt_vld & ~sel_write) ? gnt_idx : rd_src_q;
  end

  // State registers; last resets to 1 so port 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q    <= 1'b1;
      rd_pend_q <= 1'b0;
      rd_src_q  <= 1'b0;
    end else begin
      last_q    <= last_d;
      rd_pend_q <= rd_pend_d;
      rd_src_q  <= rd_src_d;
    end
  end

endmodule

// File: tb/tb_can_mem_arbiter.sv
module tb_can_mem_arbiter;

  localparam int LIMIT = 5000;

  typedef enum logic [1:0] {K_IDLE = 2'd0, K_RD = 2'd1, K_WR = 2'd2, K_RW = 2'd3} kind_t;

  typedef struct packed {
    kind_t       kind;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
  } req_t;

  logic        clk;
  logic        reset;
  logic        preload;
  logic [9:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        mem_clken;
  logic [31:0] mem_readdata;

  can_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) m0_if ();
  can_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) m1_if ();

  can_mem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .m0             (m0_if),
    .m1             (m1_if),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return (i == 1023) ? 32'hAAAA_AAAA : (32'hCAFE_0000 | 32'(i));
  endfunction

  // RAM: registered read, byte-lane writes.
  logic [31:0] ram [1024];
  logic [31:0] ram_rd_q;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_val(i);
    end else if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        ram_rd_q <= ram[mem_address];
      end
    end
  end
  assign mem_readdata = ram_rd_q;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: shared memory contents, arbitration pointer, and
  // per-port queues of read data still owed to each master.
  logic [31:0] shadow [1024];
  logic [31:0] eq0[$];
  logic [31:0] eq1[$];
  logic        last_m;
  logic [1:0]  exp_v;

  always @(negedge clk) begin
    logic r0, r1, w0, w1, gv, gi, gw;
    logic [9:0] ga;
    if (preload) for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);
    chk("clken", 32'(mem_clken), 32'd1);
    if (reset) begin
      chk("rst_wait0", 32'(m0_if.waitrequest), 32'd1);
      chk("rst_wait1", 32'(m1_if.waitrequest), 32'd1);
      chk("rst_cs", 32'(mem_chipselect), 32'd0);
      chk("rst_mwrite", 32'(mem_write), 32'd0);
      chk("rst_valid0", 32'(m0_if.readdatavalid), 32'd0);
      chk("rst_valid1", 32'(m1_if.readdatavalid), 32'd0);
      eq0.delete();
      eq1.delete();
      last_m = 1'b1;
      exp_v  = 2'b00;
    end else begin
      chk("valid0", 32'(m0_if.readdatavalid), 32'(exp_v[0]));
      chk("valid1", 32'(m1_if.readdatavalid), 32'(exp_v[1]));
      if (m0_if.readdatavalid && eq0.size() != 0) chk("rdata0", m0_if.readdata, eq0.pop_front());
      if (m1_if.readdatavalid && eq1.size() != 0) chk("rdata1", m1_if.readdata, eq1.pop_front());
      r0 = m0_if.read | m0_if.write;
      r1 = m1_if.read | m1_if.write;
      w0 = m0_if.write;
      w1 = m1_if.write;
      gv = r0 | r1;
`ifdef CAN_MEM_ARB_FIXED_PRIO_EN
      gi = ~r0;
`else
      // Lone requester wins; on contention the port not served last wins.
      gi = (r0 && r1) ? (last_m == 1'b0) : r1;
`endif
      gw = gi ? w1 : w0;
      ga = gi ? m1_if.address : m0_if.address;
      chk("wait0", 32'(m0_if.waitrequest), 32'(!(gv && !gi)));
      chk("wait1", 32'(m1_if.waitrequest), 32'(!(gv && gi)));
      chk("cs", 32'(mem_chipselect), 32'(gv));
      chk("mwrite", 32'(mem_write), 32'(gv && gw));
      chk("maddr", 32'(mem_address), 32'(gv ? ga : m0_if.address));
      exp_v = 2'b00;
      if (gv) begin
        last_m = gi;
        if (gw) begin
          chk("mwdata", mem_writedata, gi ? m1_if.writedata : m0_if.writedata);
          chk("mbe", 32'(mem_byteenable), 32'(gi ? m1_if.byteenable : m0_if.byteenable));
          for (int b = 0; b < 4; b++)
            if ((gi ? m1_if.byteenable[b] : m0_if.byteenable[b]))
              shadow[ga][8*b +: 8] = gi ? m1_if.writedata[8*b +: 8] : m0_if.writedata[8*b +: 8];
        end else begin
          if (gi) eq1.push_back(shadow[ga]);
          else    eq0.push_back(shadow[ga]);
          exp_v[gi] = 1'b1;
        end
      end
    end
  end

  // Masters: each port works through its own request list, holding a
  // request while stalled.
  req_t q0[$];
  req_t q1[$];
  localparam req_t IDLE_R = '{kind: K_IDLE, addr: 10'd0, be: 4'd0, data: 32'd0};

  task automatic drive0(input req_t r);
    m0_if.read       = (r.kind == K_RD) || (r.kind == K_RW);
    m0_if.write      = (r.kind == K_WR) || (r.kind == K_RW);
    m0_if.address    = r.addr;
    m0_if.byteenable = r.be;
    m0_if.writedata  = r.data;
  endtask

  task automatic drive1(input req_t r);
    m1_if.read       = (r.kind == K_RD) || (r.kind == K_RW);
    m1_if.write      = (r.kind == K_WR) || (r.kind == K_RW);
    m1_if.address    = r.addr;
    m1_if.byteenable = r.be;
    m1_if.writedata  = r.data;
  endtask

  task automatic step();
    logic a0, a1;
    @(negedge clk);
    a0 = !m0_if.waitrequest || !(m0_if.read || m0_if.write);
    a1 = !m1_if.waitrequest || !(m1_if.read || m1_if.write);
    @(posedge clk);
    #1;
    if (a0) drive0((q0.size() != 0) ? q0.pop_front() : IDLE_R);
    if (a1) drive1((q1.size() != 0) ? q1.pop_front() : IDLE_R);
  endtask

  task automatic run_all(input string nm);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || m0_if.read || m0_if.write ||
            m1_if.read || m1_if.write || eq0.size() != 0 || eq1.size() != 0) && n < LIMIT) begin
      step();
      n++;
    end
    step();
    chk(nm, 32'(n < LIMIT), 32'd1);
  endtask

  function automatic req_t mk(input kind_t k, input int a, input logic [3:0] be, input logic [31:0] d);
    req_t r;
    r.kind = k;
    r.addr = 10'(a);
    r.be   = be;
    r.data = d;
    return r;
  endfunction

  function automatic req_t rand_req();
    int k = $urandom_range(0, 9);
    kind_t kd;
    int a;
    kd = (k < 2) ? K_IDLE : (k < 6) ? K_RD : (k < 9) ? K_WR : K_RW;
    a  = ($urandom_range(0, 3) == 0) ? (1023 - $urandom_range(0, 1)) : $urandom_range(0, 15);
    return mk(kd, a, 4'($urandom), $urandom);
  endfunction

  initial begin
    reset   = 1'b1;
    preload = 1'b1;
    drive0(IDLE_R);
    drive1(IDLE_R);
    repeat (3) @(posedge clk);
    #1;
    reset   = 1'b0;
    preload = 1'b0;

    // Single read from 0x005.
    q0.push_back(mk(K_RD, 'h005, 4'hF, 32'd0));
    run_all("drain_single");

    // Byte write to the top word, then read it back.
    q1.push_back(mk(K_WR, 'h3FF, 4'b0101, 32'h1122_3344));
    q0.push_back(IDLE_R);
    q0.push_back(mk(K_RD, 'h3FF, 4'hF, 32'd0));
    run_all("drain_bytewr");

    // Read, overlapping write to the same word, re-read.
    q0.push_back(mk(K_RD, 'h001, 4'hF, 32'd0));
    q0.push_back(mk(K_RD, 'h001, 4'hF, 32'd0));
    q1.push_back(IDLE_R);
    q1.push_back(mk(K_WR, 'h001, 4'hF, 32'd0));
    run_all("drain_mixed");

    // Reset while an m1 read is in flight.
    q1.push_back(mk(K_RD, 'h020, 4'hF, 32'd0));
    step();
    step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Continuous contention right after reset release.
    for (int i = 0; i < 6; i++) begin
      q0.push_back(mk(K_RD, 'h010, 4'hF, 32'd0));
      q1.push_back(mk(K_RD, 'h020, 4'hF, 32'd0));
    end
    run_all("drain_contend");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      q0.push_back(rand_req());
      q1.push_back(rand_req());
    end
    run_all("drain_random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/can_mem_arbiter.md
# can_mem_arbiter

Two-port Avalon-MM arbiter sharing the CAN controller's single-port 1024×32 on-chip RAM between the Nios II data master (port 0) and the CAN frame-buffer DMA engine (port 1). It grants at most one access per clock to the RAM slave, round-robin by default. It tracks the RAM's one-cycle read latency so that each read returns `readdatavalid` only to the master that issued it.

## Interface
Parameters:
- `ADDR_W`, 10: word address width; RAM depth is 2^ADDR_W.
- `DATA_W`, 32: data width; byteenable width is DATA_W/8.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `m0_address` / `m1_address`  in  ADDR_W  word address.
- `m0_byteenable` / `m1_byteenable`  in  DATA_W/8  byte lanes for writes.
- `m0_read` / `m1_read`  in  1  read request.
- `m0_write` / `m1_write`  in  1  write request.
- `m0_writedata` / `m1_writedata`  in  DATA_W  write data.
- `m0_waitrequest` / `m1_waitrequest`  out  1  high = request not accepted this cycle.
- `m0_readdata` / `m1_readdata`  out  DATA_W  read data.
- `m0_readdatavalid` / `m1_readdatavalid`  out  1  readdata valid strobe.
- `mem_address`  out  ADDR_W  to RAM address.
- `mem_byteenable`  out  DATA_W/8  to RAM byteenable.
- `mem_chipselect`  out  1  to RAM chipselect.
- `mem_write`  out  1  to RAM write.
- `mem_writedata`  out  DATA_W  to RAM writedata.
- `mem_clken`  out  1  to RAM clken; constant 1.
- `mem_readdata`  in  DATA_W  from RAM; unregistered output, valid 1 cycle after the address is presented.

## Operation
- Request `reqN = mN_read | mN_write`. A master asserting both read and write in the same cycle is illegal; the arbiter treats it as a write.
- Grant is combinational each cycle from `req0`, `req1`, and the `last` register (index of the last granted port).
  - Only one port requesting: that port wins.
  - Both ports requesting: the port ≠ `last` wins.
- On a grant:
  - `mem_*` is driven from the granted port.
  - `mem_chipselect` = 1 and `mem_write` = granted write.
  - The granted port's `mN_waitrequest` = 0 and the access completes that cycle.
  - `last` ← granted index at the clock edge.
- `mN_waitrequest` = 1 whenever port N is not granted, including when it is idle.
  - The master must hold address, data and controls stable while stalled.
- With no grant, `mem_chipselect` = 0, `mem_write` = 0, and the `mem_*` address/data outputs hold port 0's values.
- Read tracking: registers `rd_pend` (1 bit) and `rd_src` (1 bit).
  - Both are set on a granted read.
  - Next cycle: `m[rd_src]_readdatavalid` = 1 and `m[rd_src]_readdata` = `mem_readdata`.
  - `mN_readdata` is `mem_readdata` to both ports unconditionally; only the valid strobe is steered.
- Back-to-back reads are fully pipelined: one grant per cycle, one valid per cycle, in issue order.
- A write granted in the cycle where the previous read's data returns is legal and does not disturb that data (single port; the read completed at the prior edge).
- No fixed-priority starvation: under continuous requests from both ports, grants alternate 0,1,0,1.

## Timing
- Reset (synchronous, `reset` = 1 at the edge):
  - `last` ← 1, so port 0 wins the first contention.
  - `rd_pend` ← 0 and `rd_src` ← 0.
- Output values while in reset:
  - `mN_readdatavalid` = 0.
  - `mN_waitrequest` = 1 (grants are blocked).
  - `mem_chipselect` = 0 and `mem_write` = 0.
  - `mem_clken` = 1.
- Reset asserted mid-read: the pending `readdatavalid` is dropped and the master must reissue.
- Read latency: grant in cycle T → `readdatavalid` in T+1. Write latency: 0 (committed at the T edge).
- Grant path is combinational from request to `waitrequest` and `mem_*`. There are no registers on the grant path, so there is no arbitration bubble.

## Configuration
- `CAN_MEM_ARB_FIXED_PRIO_EN`
  - Defined: port 0 (CPU) always wins contention and `last` is unused. Port 1 is served only when `req0` = 0.
  - Undefined (default): round-robin as above.
- Reset values and read tracking are identical in both modes.

## Test plan
- Single read: after reset, m0 reads address 0x005 with RAM preloaded 0x5 = 0xCAFE0005 → `m0_waitrequest` = 0 in T, `m0_readdatavalid` = 1 with 0xCAFE0005 in T+1, `m1_readdatavalid` = 0 throughout.
- Contention:
  - Round-robin: m0 and m1 both read continuously from T0 (m0 addr 0x010, m1 addr 0x020) → grants 0,1,0,1; valids alternate m0/m1 from T0+1; each sees the correct data.
  - `CAN_MEM_ARB_FIXED_PRIO_EN` defined: m1 stalls until m0 drops `read`.
- Byte write: m1 writes 0x11223344 with byteenable 4'b0101 to 0x3FF (prior content 0xAAAAAAAA), then m0 reads 0x3FF → 0xAA22AA44. This also checks the top address with no wrap to 0x000.
- Mixed pipeline: m0 reads 0x001 in T while m1 waits; m1 writes 0x001 = 0x0 in T+1 → m0 gets the old value in T+1; a subsequent m0 read returns 0x0.
- Reset mid-read: grant an m1 read in T and assert `reset` in T+1 → `m1_readdatavalid` = 0 in T+1 and T+2. After release, contention from both ports grants port 0 first.
